// File: rtl/rom_read_arbiter_if.sv
// Bundle of the two requester handshakes plus the ROM read port.
// The slave modport is the arbiter's view; master is the requesters/ROM side.
interface rom_read_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        dbg_err;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, rom_data,
    input  if_ack, if_rdata, if_err, dbg_ack, dbg_rdata, dbg_err, rom_nrd, rom_addr
  );

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, rom_data,
    output if_ack, if_rdata, if_err, dbg_ack, dbg_rdata, dbg_err, rom_nrd, rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-requester arbiter for the instruction ROM read port: IF has priority,
// DBG is forced after STARVE_MAX consecutive IF wins while it waits.
module rom_read_arbiter #(
  parameter int unsigned ROM_BYTES  = 100,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  rom_read_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [31:0]      MAX_ADDR = 32'(ROM_BYTES - 4);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);

  logic [1:0]       state_q, state_d;
  logic             own_dbg_q, own_dbg_d;
  logic [31:0]      addr_q, addr_d;
  logic             legal_q, legal_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dbg_rdata_q, dbg_rdata_d;

  logic        if_elig, dbg_elig, pick_dbg;
  logic [31:0] sel_addr, word;

  // In RESP the current owner is masked so the other side gets the next slot.
  assign if_elig  = bus.if_req  && !(state_q == S_RESP && !own_dbg_q);
  assign dbg_elig = bus.dbg_req && !(state_q == S_RESP &&  own_dbg_q);
  assign pick_dbg = dbg_elig && (!if_elig || starve_q == CNT_MAX);
  assign sel_addr = pick_dbg ? bus.dbg_addr : bus.if_addr;
  assign word     = legal_q ? bus.rom_data : 32'd0;

  always_comb begin
    state_d     = state_q;
    own_dbg_d   = own_dbg_q;
    addr_d      = addr_q;
    legal_d     = legal_q;
    err_d       = err_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (if_elig || dbg_elig) begin
          state_d   = S_READ;
          own_dbg_d = pick_dbg;
          addr_d    = sel_addr;
          legal_d   = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);
          if (pick_dbg || !bus.dbg_req) starve_d = '0;
          else if (starve_q != CNT_MAX) starve_d = starve_q + 1'b1;
        end
      end
      S_READ: begin
        state_d = S_RESP;
        err_d   = !legal_q;
        if (own_dbg_q) dbg_rdata_d = word;
        else           if_rdata_d  = word;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_dbg_q   <= 1'b0;
      addr_q      <= 32'd0;
      legal_q     <= 1'b0;
      err_q       <= 1'b0;
      starve_q    <= '0;
      if_rdata_q  <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      own_dbg_q   <= own_dbg_d;
      addr_q      <= addr_d;
      legal_q     <= legal_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Outputs are forced to their reset values while rst is high, whatever the state.
  logic resp, reading;
  assign resp    = (state_q == S_RESP) && !rst;
  assign reading = (state_q == S_READ) && !rst;

  assign bus.if_ack    = resp && !own_dbg_q;
  assign bus.dbg_ack   = resp &&  own_dbg_q;
  assign bus.if_err    = bus.if_ack  && err_q;
  assign bus.dbg_err   = bus.dbg_ack && err_q;
  assign bus.if_rdata  = rst ? 32'd0 : if_rdata_q;
  assign bus.dbg_rdata = rst ? 32'd0 : dbg_rdata_q;
  assign bus.rom_nrd   = !(reading && legal_q);
  assign bus.rom_addr  = reading ? addr_q : 32'd0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench: directed cases plus random traffic against a
// transaction-level model of the arbiter and a byte-array ROM.
module tb_rom_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rom_read_arbiter_if bus ();
  rom_read_arbiter #(.ROM_BYTES(100), .STARVE_MAX(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rom [100];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    if (a > 32'd96) return 32'hDEADBEEF;
    i = int'(a);
    return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && ({32'd0, a} + 64'd3 <= 64'd99);
  endfunction

  always_comb bus.rom_data = word_at(bus.rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at most one transaction in flight, aged 1 (ROM access) or 2 (response).
  int          m_who = 0;   // 0 none, 1 IF, 2 DBG
  int          m_age = 0;
  logic [31:0] m_addr = 0;
  int          m_cnt = 0;
  logic [31:0] m_ifr = 0, m_dbgr = 0;
  logic        e_nrd, e_ia, e_da, e_ie, e_de;
  logic [31:0] e_ra, e_ir, e_dr, m_res;
  bit          ie, de, gd;

  always @(negedge clk) begin
    m_res = legal(m_addr) ? word_at(m_addr) : 32'd0;
    e_nrd = 1'b1; e_ra = 0; e_ia = 0; e_da = 0; e_ie = 0; e_de = 0;
    e_ir = m_ifr; e_dr = m_dbgr;
    if (rst) begin
      e_ir = 0; e_dr = 0;
    end else if (m_who != 0 && m_age == 1) begin
      e_nrd = !legal(m_addr);
      e_ra  = m_addr;
    end else if (m_who != 0 && m_age == 2) begin
      if (m_who == 1) begin e_ia = 1; e_ie = !legal(m_addr); e_ir = m_res; end
      else            begin e_da = 1; e_de = !legal(m_addr); e_dr = m_res; end
    end
    chk("if_ack",    {31'd0, bus.if_ack},  {31'd0, e_ia});
    chk("dbg_ack",   {31'd0, bus.dbg_ack}, {31'd0, e_da});
    chk("if_err",    {31'd0, bus.if_err},  {31'd0, e_ie});
    chk("dbg_err",   {31'd0, bus.dbg_err}, {31'd0, e_de});
    chk("if_rdata",  bus.if_rdata,  e_ir);
    chk("dbg_rdata", bus.dbg_rdata, e_dr);
    chk("rom_nrd",   {31'd0, bus.rom_nrd}, {31'd0, e_nrd});
    chk("rom_addr",  bus.rom_addr,  e_ra);
    // advance model to the next cycle
    if (rst) begin
      m_who = 0; m_age = 0; m_cnt = 0; m_ifr = 0; m_dbgr = 0; m_addr = 0;
    end else begin
      m_ifr = e_ir; m_dbgr = e_dr;
      if (m_who == 0 || m_age == 2) begin
        ie = bus.if_req  && !(m_age == 2 && m_who == 1);
        de = bus.dbg_req && !(m_age == 2 && m_who == 2);
        if (ie || de) begin
          gd = de && (!ie || m_cnt == 4);
          if (gd || !bus.dbg_req) m_cnt = 0;
          else m_cnt = (m_cnt + 1 > 4) ? 4 : m_cnt + 1;
          m_who  = gd ? 2 : 1;
          m_addr = gd ? bus.dbg_addr : bus.if_addr;
          m_age  = 1;
        end else begin
          m_who = 0; m_age = 0;
        end
      end else begin
        m_age = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'(4 * $urandom_range(0, 24));
      3:       return ($urandom_range(0, 1) == 0) ? 32'd96 : 32'd100;
      4:       return 32'($urandom_range(0, 99));
      default: return ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFC : $urandom;
    endcase
  endfunction

  logic [31:0] t2a [4];
  bit          t2ok [4];

  initial begin
    for (int i = 0; i < 100; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
    t2a[0] = 32'd6;   t2a[1] = 32'd96; t2a[2] = 32'd100; t2a[3] = 32'hFFFFFFFC;
    t2ok[0] = 0;      t2ok[1] = 1;     t2ok[2] = 0;      t2ok[3] = 0;

    // Reset held with both requests high: outputs stay at reset values
    bus.if_req = 1; bus.if_addr = 0; bus.dbg_req = 1; bus.dbg_addr = 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_if_ack",  {31'd0, bus.if_ack},  0);
      chk("rst_dbg_ack", {31'd0, bus.dbg_ack}, 0);
      chk("rst_nrd",     {31'd0, bus.rom_nrd}, 1);
      chk("rst_raddr",   bus.rom_addr, 0);
      chk("rst_rdata",   bus.if_rdata | bus.dbg_rdata, 0);
    end
    rst = 0; bus.if_req = 0; bus.dbg_req = 0;
    tick();

    // Basic IF read of word 0
    bus.if_req = 1; bus.if_addr = 0;
    tick();
    chk("t1_nrd", {31'd0, bus.rom_nrd}, 0);
    tick();
    chk("t1_ack",   {31'd0, bus.if_ack}, 1);
    chk("t1_rdata", bus.if_rdata, 32'h12345678);
    chk("t1_err",   {31'd0, bus.if_err}, 0);
    bus.if_req = 0;
    tick();
    chk("t1_hold", bus.if_rdata, 32'h12345678);

    // Legality boundaries on DBG
    for (int i = 0; i < 4; i++) begin
      bus.dbg_req = 1; bus.dbg_addr = t2a[i];
      tick();
      chk("t2_nrd", {31'd0, bus.rom_nrd}, {31'd0, !t2ok[i]});
      tick();
      chk("t2_ack",   {31'd0, bus.dbg_ack}, 1);
      chk("t2_err",   {31'd0, bus.dbg_err}, {31'd0, !t2ok[i]});
      chk("t2_rdata", bus.dbg_rdata, t2ok[i] ? word_at(t2a[i]) : 32'd0);
      bus.dbg_req = 0;
      tick();
    end

    // Simultaneous requests: IF first, DBG granted in IF's response cycle
    bus.if_req = 1; bus.if_addr = 4; bus.dbg_req = 1; bus.dbg_addr = 12;
    tick();
    chk("t3_raddr_if", bus.rom_addr, 4);
    tick();
    chk("t3_if_ack",  {31'd0, bus.if_ack},  1);
    chk("t3_dbg_no",  {31'd0, bus.dbg_ack}, 0);
    bus.if_req = 0;
    tick();
    chk("t3_raddr_dbg", bus.rom_addr, 12);
    tick();
    chk("t3_dbg_ack", {31'd0, bus.dbg_ack}, 1);
    chk("t3_dbg_rd",  bus.dbg_rdata, word_at(12));
    bus.dbg_req = 0;
    tick();

    // Reset during READ drops the transaction; re-presented request acks 2 cycles later
    bus.if_req = 1; bus.if_addr = 8;
    tick();
    chk("t5_nrd_pre", {31'd0, bus.rom_nrd}, 0);
    rst = 1;
    #1;
    chk("t5_nrd_rst", {31'd0, bus.rom_nrd}, 1);
    chk("t5_ack_rst", {31'd0, bus.if_ack}, 0);
    tick();
    rst = 0;
    chk("t5_ack0", {31'd0, bus.if_ack}, 0);
    chk("t5_nrd0", {31'd0, bus.rom_nrd}, 1);
    tick();
    chk("t5_ack1", {31'd0, bus.if_ack}, 0);
    tick();
    chk("t5_ack2", {31'd0, bus.if_ack}, 1);
    chk("t5_rd",   bus.if_rdata, word_at(8));
    bus.if_req = 0;
    tick();

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (bus.if_req && bus.if_ack) begin
        bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = rand_addr();
      end else if (bus.if_req) begin
        if ($urandom_range(0, 19) == 0) bus.if_req = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        bus.if_req = 1; bus.if_addr = rand_addr();
      end
      if (bus.dbg_req && bus.dbg_ack) begin
        bus.dbg_req = 1'($urandom_range(0, 1)); bus.dbg_addr = rand_addr();
      end else if (bus.dbg_req) begin
        if ($urandom_range(0, 19) == 0) bus.dbg_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.dbg_req = 1; bus.dbg_addr = rand_addr();
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 0; bus.if_req = 0; bus.dbg_req = 0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
